// File: rtl/z32_mem_fabric.sv
// Zaks32 memory/MMIO fabric: priority region decode, req/ack slave handshake with timeout, error response.
// Latency 1 cycle on decode error, 2 + wait cycles otherwise; optional error log under Z32_FABRIC_ERRLOG_EN.
module z32_mem_fabric #(
  parameter int                    NUM_SLV     = 4,
  parameter int                    DW          = 32,
  parameter logic [NUM_SLV*32-1:0] REGION_BASE = {32'h1000_1000, 32'h1000_0000, 32'h0000_0000, 32'h0000_0000},
  parameter logic [NUM_SLV*32-1:0] REGION_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFF0_0000, 32'hFFFF_0000},
  parameter logic [NUM_SLV-1:0]    REGION_RO   = 4'b0001,
  parameter int                    TIMEOUT_CYC = 16,
  parameter logic [DW-1:0]         ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m_req,
  input  logic                  m_we,
  input  logic [31:0]           m_addr,
  input  logic [DW-1:0]         m_wdata,
  input  logic [DW/8-1:0]       m_be,
  output logic                  m_ready,
  output logic [DW-1:0]         m_rdata,
  output logic                  m_err,
  output logic                  m_busy,
  output logic [NUM_SLV-1:0]    s_req,
  output logic                  s_we,
  output logic [31:0]           s_addr,
  output logic [DW-1:0]         s_wdata,
  output logic [DW/8-1:0]       s_be,
  input  logic [NUM_SLV-1:0]    s_ack,
  input  logic [NUM_SLV*DW-1:0] s_rdata
`ifdef Z32_FABRIC_ERRLOG_EN
  ,
  output logic [31:0]           err_addr,
  output logic [15:0]           err_cnt,
  output logic [1:0]            err_cause
`endif
);

  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       sel_q, sel_d;
  logic [NUM_SLV-1:0]  s_req_q, s_req_d;
  logic                s_we_q, s_we_d;
  logic [31:0]         s_addr_q, s_addr_d;
  logic [DW-1:0]       s_wdata_q, s_wdata_d;
  logic [DW/8-1:0]     s_be_q, s_be_d;
  logic                m_ready_q, m_ready_d;
  logic                m_err_q, m_err_d;
  logic [DW-1:0]       m_rdata_q, m_rdata_d;

  // Returns {hit, index}; the downward scan leaves the lowest matching index.
  function automatic logic [IW:0] decode(input logic [31:0] a);
    logic [IW:0] r;
    r = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((a & REGION_MASK[i*32 +: 32]) == REGION_BASE[i*32 +: 32]) r = {1'b1, IW'(i)};
    end
    return r;
  endfunction

  logic [IW:0]   dec_m;
  logic          timeout_hit;

  assign dec_m       = decode(m_addr);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    s_req_d   = s_req_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    s_be_d    = s_be_q;
    m_ready_d = 1'b0;
    m_err_d   = m_err_q;
    m_rdata_d = m_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (m_req) begin
          s_we_d    = m_we;
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_be_d    = m_be;
          if (!dec_m[IW] || (m_we && REGION_RO[dec_m[IW-1:0]])) begin
            state_d   = ST_RESP;
            m_ready_d = 1'b1;
            m_err_d   = 1'b1;
            m_rdata_d = ERR_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
            sel_d   = dec_m[IW-1:0];
            s_req_d = NUM_SLV'(1) << dec_m[IW-1:0];
          end
        end
      end
      ST_WAIT: begin
        // A late ack on the timeout edge still completes the transfer cleanly.
        if (s_ack[sel_q]) begin
          state_d   = ST_RESP;
          s_req_d   = '0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b0;
          m_rdata_d = s_we_q ? '0 : s_rdata[sel_q*DW +: DW];
        end else if (timeout_hit) begin
          state_d   = ST_RESP;
          s_req_d   = '0;
          m_ready_d = 1'b1;
          m_err_d   = 1'b1;
          m_rdata_d = ERR_DATA;
        end else if (cnt_q != {CW{1'b1}}) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      s_req_q   <= '0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      s_be_q    <= '0;
      m_ready_q <= 1'b0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      s_req_q   <= s_req_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      s_be_q    <= s_be_d;
      m_ready_q <= m_ready_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
    end
  end

  assign m_ready = m_ready_q;
  assign m_rdata = m_rdata_q;
  assign m_err   = m_err_q;
  assign m_busy  = (state_q != ST_IDLE);
  assign s_req   = s_req_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_wdata = s_wdata_q;
  assign s_be    = s_be_q;

`ifdef Z32_FABRIC_ERRLOG_EN
  // Cause is recovered in the RESP cycle by re-decoding the held request; anything decodable must have timed out.
  logic [IW:0]  dec_s;
  logic [31:0]  err_addr_q;
  logic [15:0]  err_cnt_q;
  logic [1:0]   err_cause_q, cause_d;

  assign dec_s   = decode(s_addr_q);
  assign cause_d = !dec_s[IW] ? 2'd1 :
                   (s_we_q && REGION_RO[dec_s[IW-1:0]]) ? 2'd2 : 2'd3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_addr_q  <= '0;
      err_cnt_q   <= '0;
      err_cause_q <= '0;
    end else if (m_ready_q && m_err_q) begin
      err_addr_q  <= s_addr_q;
      err_cause_q <= cause_d;
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_addr  = err_addr_q;
  assign err_cnt   = err_cnt_q;
  assign err_cause = err_cause_q;
`endif

endmodule

// File: tb/tb_z32_mem_fabric.sv
// Directed bench for z32_mem_fabric: decode, wait states, protection, timeout, reset and back-to-back traffic.
module tb_z32_mem_fabric;
  logic         clk = 1'b0;
  logic         rst_n, m_req, m_we;
  logic [31:0]  m_addr, m_wdata;
  logic [3:0]   m_be;
  logic         m_ready, m_err, m_busy;
  logic [31:0]  m_rdata;
  logic [3:0]   s_req;
  logic         s_we;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_be, s_ack;
  logic [127:0] s_rdata;
`ifdef Z32_FABRIC_ERRLOG_EN
  logic [31:0]  err_addr;
  logic [15:0]  err_cnt;
  logic [1:0]   err_cause;
`endif
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  z32_mem_fabric dut (
    .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_be(m_be), .m_ready(m_ready), .m_rdata(m_rdata),
    .m_err(m_err), .m_busy(m_busy), .s_req(s_req), .s_we(s_we), .s_addr(s_addr),
    .s_wdata(s_wdata), .s_be(s_be), .s_ack(s_ack), .s_rdata(s_rdata)
`ifdef Z32_FABRIC_ERRLOG_EN
    , .err_addr(err_addr), .err_cnt(err_cnt), .err_cause(err_cause)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request for exactly one sampling edge, then withdraws it.
  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    m_req = 1'b1; m_we = we; m_addr = a; m_wdata = d; m_be = be;
    tick();
    m_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_req = 1'b1; m_we = 1'b1; m_addr = 32'h10; m_wdata = 32'h1; m_be = 4'hF;
    s_ack = 4'hF; s_rdata = '1;
    tick(); tick();
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rst_m_ready: got %b want 0", m_ready); end
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL rst_m_err: got %b want 0", m_err); end
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL rst_m_rdata: got %h want 0", m_rdata); end
    checks++; if (m_busy !== 1'b0) begin errors++; $display("FAIL rst_m_busy: got %b want 0", m_busy); end
    checks++; if (s_req !== 4'b0) begin errors++; $display("FAIL rst_s_req: got %b want 0", s_req); end
    checks++; if ({s_we, s_addr, s_wdata, s_be} !== 69'h0) begin errors++; $display("FAIL rst_s_bus: got %h want 0", {s_we, s_addr, s_wdata, s_be}); end
    m_req = 1'b0; m_we = 1'b0; s_ack = 4'h0; s_rdata = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_rom_read();
    s_rdata[0 +: 32] = 32'h1234_5678; s_rdata[32 +: 32] = 32'h9999_9999;
    issue(1'b0, 32'h0000_0010, 32'h0, 4'hF);
    checks++; if (s_req !== 4'b0001) begin errors++; $display("FAIL rom_s_req: got %b want 0001", s_req); end
    checks++; if (m_ready !== 1'b0 || m_busy !== 1'b1) begin errors++; $display("FAIL rom_wait: got rdy=%b busy=%b want 0 1", m_ready, m_busy); end
    s_ack = 4'b0001;
    tick();
    s_ack = 4'b0000;
    checks++; if (m_ready !== 1'b1 || m_err !== 1'b0) begin errors++; $display("FAIL rom_resp: got rdy=%b err=%b want 1 0", m_ready, m_err); end
    checks++; if (m_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rom_rdata: got %h want 12345678", m_rdata); end
    checks++; if (s_req !== 4'b0) begin errors++; $display("FAIL rom_s_req_clr: got %b want 0", s_req); end
    tick();
    checks++; if (m_ready !== 1'b0 || m_busy !== 1'b0 || m_rdata !== 32'h1234_5678) begin errors++; $display("FAIL rom_after: got rdy=%b busy=%b rdata=%h want 0 0 12345678", m_ready, m_busy, m_rdata); end
  endtask

  task automatic test_ram_write();
    int hi;
    s_rdata[32 +: 32] = 32'h5555_AAAA;
    issue(1'b1, 32'h0001_0040, 32'hCAFE_F00D, 4'hF);
    checks++; if (s_we !== 1'b1 || s_wdata !== 32'hCAFE_F00D || s_be !== 4'hF || s_addr !== 32'h0001_0040) begin errors++; $display("FAIL ram_latch: got we=%b wd=%h be=%h a=%h want 1 cafef00d f 00010040", s_we, s_wdata, s_be, s_addr); end
    hi = (s_req === 4'b0010 && m_ready === 1'b0) ? 1 : 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (s_req === 4'b0010 && m_ready === 1'b0) hi++;
    end
    checks++; if (hi != 4) begin errors++; $display("FAIL ram_hold: got %0d want 4 cycles of s_req=0010", hi); end
    s_ack = 4'b0010;
    tick();
    s_ack = 4'b0000;
    checks++; if (m_ready !== 1'b1 || m_err !== 1'b0) begin errors++; $display("FAIL ram_resp: got rdy=%b err=%b want 1 0", m_ready, m_err); end
    checks++; if (m_rdata !== 32'h0) begin errors++; $display("FAIL ram_rdata: got %h want 0", m_rdata); end
    tick();
  endtask

  task automatic test_ro_write();
    issue(1'b1, 32'h0000_0100, 32'h1111_2222, 4'hF);
    checks++; if (m_ready !== 1'b1 || m_err !== 1'b1) begin errors++; $display("FAIL ro_resp: got rdy=%b err=%b want 1 1", m_ready, m_err); end
    checks++; if (m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ro_rdata: got %h want deadbeef", m_rdata); end
    checks++; if (s_req !== 4'b0) begin errors++; $display("FAIL ro_s_req: got %b want 0", s_req); end
    tick();
    checks++; if (m_ready !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL ro_after: got rdy=%b busy=%b want 0 0", m_ready, m_busy); end
`ifdef Z32_FABRIC_ERRLOG_EN
    checks++; if (err_cause !== 2'd2 || err_cnt !== 16'd1 || err_addr !== 32'h100) begin errors++; $display("FAIL ro_log: got cause=%0d cnt=%0d addr=%h want 2 1 00000100", err_cause, err_cnt, err_addr); end
`endif
  endtask

  task automatic test_unmapped();
    issue(1'b0, 32'h2000_0000, 32'h0, 4'hF);
    checks++; if (m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL unm_resp: got rdy=%b err=%b rdata=%h want 1 1 deadbeef", m_ready, m_err, m_rdata); end
    checks++; if (s_req !== 4'b0) begin errors++; $display("FAIL unm_s_req: got %b want 0", s_req); end
    tick();
`ifdef Z32_FABRIC_ERRLOG_EN
    checks++; if (err_cause !== 2'd1 || err_cnt !== 16'd2 || err_addr !== 32'h2000_0000) begin errors++; $display("FAIL unm_log: got cause=%0d cnt=%0d addr=%h want 1 2 20000000", err_cause, err_cnt, err_addr); end
`endif
  endtask

  task automatic test_timeout();
    int hi;
    issue(1'b0, 32'h1000_1004, 32'h0, 4'hF);
    s_ack = 4'b0111;
    hi = (s_req === 4'b1000 && m_ready === 1'b0) ? 1 : 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (s_req === 4'b1000 && m_ready === 1'b0) hi++;
    end
    checks++; if (hi != 16) begin errors++; $display("FAIL to_hold: got %0d want 16 cycles of s_req=1000", hi); end
    tick();
    s_ack = 4'b0000;
    checks++; if (m_ready !== 1'b1 || m_err !== 1'b1 || m_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL to_resp: got rdy=%b err=%b rdata=%h want 1 1 deadbeef", m_ready, m_err, m_rdata); end
    checks++; if (s_req !== 4'b0) begin errors++; $display("FAIL to_s_req: got %b want 0", s_req); end
    tick();
`ifdef Z32_FABRIC_ERRLOG_EN
    checks++; if (err_cause !== 2'd3 || err_cnt !== 16'd3 || err_addr !== 32'h1000_1004) begin errors++; $display("FAIL to_log: got cause=%0d cnt=%0d addr=%h want 3 3 10001004", err_cause, err_cnt, err_addr); end
`endif
  endtask

  task automatic test_timeout_ack();
    s_rdata[96 +: 32] = 32'h0000_7777;
    issue(1'b0, 32'h1000_1004, 32'h0, 4'hF);
    for (int k = 1; k <= 15; k++) tick();
    checks++; if (m_ready !== 1'b0 || s_req !== 4'b1000) begin errors++; $display("FAIL toack_pre: got rdy=%b s_req=%b want 0 1000", m_ready, s_req); end
    s_ack = 4'b1000;
    tick();
    s_ack = 4'b0000;
    checks++; if (m_ready !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'h0000_7777) begin errors++; $display("FAIL toack_resp: got rdy=%b err=%b rdata=%h want 1 0 00007777", m_ready, m_err, m_rdata); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    s_rdata[64 +: 32] = 32'hA5A5_0002;
    issue(1'b0, 32'h1000_0000, 32'h0, 4'hF);
    checks++; if (s_req !== 4'b0100) begin errors++; $display("FAIL rmw_s_req: got %b want 0100", s_req); end
    tick();
    rst_n = 1'b0;
    tick();
    checks++; if (s_req !== 4'b0 || m_ready !== 1'b0 || m_busy !== 1'b0) begin errors++; $display("FAIL rmw_reset: got s_req=%b rdy=%b busy=%b want 0 0 0", s_req, m_ready, m_busy); end
    rst_n = 1'b1;
    tick();
    checks++; if (m_ready !== 1'b0) begin errors++; $display("FAIL rmw_no_resp: got %b want 0", m_ready); end
`ifdef Z32_FABRIC_ERRLOG_EN
    checks++; if (err_cnt !== 16'd0 || err_cause !== 2'd0 || err_addr !== 32'h0) begin errors++; $display("FAIL rmw_log: got cnt=%0d cause=%0d addr=%h want 0 0 0", err_cnt, err_cause, err_addr); end
`endif
    issue(1'b0, 32'h1000_0000, 32'h0, 4'hF);
    s_ack = 4'b0100;
    tick();
    s_ack = 4'b0000;
    checks++; if (m_ready !== 1'b1 || m_err !== 1'b0 || m_rdata !== 32'hA5A5_0002) begin errors++; $display("FAIL rmw_after: got rdy=%b err=%b rdata=%h want 1 0 a5a50002", m_ready, m_err, m_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    s_rdata[0 +: 32] = 32'h1111_0001;
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_0010; m_be = 4'hF;
    tick();
    s_ack = 4'b0001;
    tick();
    s_ack = 4'b0000;
    checks++; if (m_ready !== 1'b1 || m_rdata !== 32'h1111_0001) begin errors++; $display("FAIL b2b_first: got rdy=%b rdata=%h want 1 11110001", m_ready, m_rdata); end
    m_addr = 32'h1000_0000;
    s_rdata[64 +: 32] = 32'h2222_0002;
    tick();
    checks++; if (m_ready !== 1'b0 || s_req !== 4'b0 || m_busy !== 1'b0 || s_addr !== 32'h10) begin errors++; $display("FAIL b2b_gap: got rdy=%b s_req=%b busy=%b s_addr=%h want 0 0 0 00000010", m_ready, s_req, m_busy, s_addr); end
    tick();
    checks++; if (s_req !== 4'b0100 || s_addr !== 32'h1000_0000) begin errors++; $display("FAIL b2b_second: got s_req=%b s_addr=%h want 0100 10000000", s_req, s_addr); end
    s_ack = 4'b0100;
    tick();
    s_ack = 4'b0000;
    m_req = 1'b0;
    checks++; if (m_ready !== 1'b1 || m_rdata !== 32'h2222_0002) begin errors++; $display("FAIL b2b_resp2: got rdy=%b rdata=%h want 1 22220002", m_ready, m_rdata); end
    tick();
    checks++; if (m_ready !== 1'b0 || s_req !== 4'b0) begin errors++; $display("FAIL b2b_idle: got rdy=%b s_req=%b want 0 0", m_ready, s_req); end
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_ram_write();
    test_ro_write();
    test_unmapped();
    test_timeout();
    test_timeout_ack();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/z32_mem_fabric.md
Name: z32_mem_fabric

Overview:
Parametrised memory/MMIO interconnect for the Zaks32 SoC. It sits between the core's MAR/MDR memory port and NUM_SLV slave regions (ROM, RAM, UART, timer, and later peripherals). The flat 1-cycle blocking decode is replaced by a req/ack handshake that supports slave wait states. It adds priority address decode, read-only region protection, a bus timeout and an error response.

Parameters:
NUM_SLV, 4, number of slave regions/ports
DW, 32, data width (multiple of 8)
REGION_BASE, {32'h1000_1000,32'h1000_0000,32'h0000_0000,32'h0000_0000}, packed NUM_SLV*32; entry i at bits [i*32+:32]
REGION_MASK, {32'hFFFF_FF00,32'hFFFF_FF00,32'hFFF0_0000,32'hFFFF_0000}, packed NUM_SLV*32; region i matches when (addr & MASK[i]) == BASE[i]
REGION_RO, 4'b0001, bit i=1: region i is read-only
TIMEOUT_CYC, 16, max WAIT cycles before error; 0 disables timeout
ERR_DATA, 32'hDEAD_BEEF, m_rdata value on any error response

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
m_req  in  1  master request; sampled only in IDLE
m_we  in  1  1=write, 0=read
m_addr  in  32  byte address
m_wdata  in  DW  write data
m_be  in  DW/8  byte enables
m_ready  out  1  one-cycle response strobe
m_rdata  out  DW  read data; valid while m_ready=1
m_err  out  1  error qualifier; valid while m_ready=1
m_busy  out  1  high in WAIT and RESP
s_req  out  NUM_SLV  one-hot slave request
s_we  out  1  latched m_we
s_addr  out  32  latched m_addr
s_wdata  out  DW  latched m_wdata
s_be  out  DW/8  latched m_be
s_ack  in  NUM_SLV  slave acknowledge
s_rdata  in  NUM_SLV*DW  slave read data; slice i at [i*DW+:DW]

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, timeout counter=0. All outputs 0: m_ready, m_err, m_rdata, m_busy, s_req, s_we, s_addr, s_wdata, s_be. Reset mid-WAIT drops s_req at that edge; no response is issued.
- FSM states: IDLE, WAIT, RESP.
- IDLE with m_req=1: latch m_we/addr/wdata/be onto the s_* registers, then decode.
  - Hit index = lowest i with a region match (lower index has priority on overlap).
  - No hit -> RESP with err=1.
  - Hit with m_we=1 and REGION_RO[i]=1 -> RESP with err=1; s_req stays 0.
  - Otherwise -> WAIT with s_req[i]=1 and counter=0.
- WAIT:
  - s_req[i] is held until s_ack[i]=1 is sampled.
  - On ack: clear s_req, capture s_rdata slice i (reads only; writes return 0), go to RESP with err=0.
  - No ack: increment counter. If TIMEOUT_CYC!=0 and the counter reaches TIMEOUT_CYC-1 without ack, clear s_req and go to RESP with err=1.
  - s_ack on non-selected bits is ignored.
  - An ack on the same edge as the timeout wins: response is err=0.
- RESP: m_ready=1 for exactly one cycle. Error responses drive m_rdata=ERR_DATA and m_err=1. Then go to IDLE.
- Latency from m_req sampled in IDLE to m_ready:
  - Error decode: 1 cycle.
  - Zero-wait slave (ack high in the first WAIT cycle): 2 cycles.
  - Each additional wait cycle adds 1.
- m_req is ignored outside IDLE. The master drops m_req while m_ready=1 unless it issues a back-to-back request. m_req still high in IDLE is a new request, giving a throughput of 1 txn per 3 cycles with a zero-wait slave.
- m_rdata/m_err hold their last value after RESP until the next response; they are meaningful only when m_ready=1.
- The timeout counter width is $clog2(TIMEOUT_CYC+1) and saturates; it never wraps.

Optional Feature:
Z32_FABRIC_ERRLOG_EN.
- Defined: adds outputs err_addr[31:0], err_cnt[15:0] and err_cause[1:0] (1=unmapped, 2=RO write, 3=timeout).
  - On every error RESP: latch err_addr=s_addr and err_cause, and increment err_cnt, saturating at 16'hFFFF.
  - All three are cleared by reset only.
- Undefined: these ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Read 0x0000_0010 with ROM slave (idx0) acking in the first WAIT cycle, rdata 0x1234_5678 -> s_req=4'b0001 and never 4'b0010; m_ready 2 cycles after request; m_rdata=0x1234_5678, m_err=0.
- Write 0x0001_0040 = 0xCAFE_F00D, be=4'hF, RAM slave acks after 3 wait cycles -> s_req=4'b0010 held 4 cycles; m_ready at cycle 5; m_err=0; s_wdata=0xCAFE_F00D.
- Write to 0x0000_0100 (RO ROM) -> s_req stays 0; m_ready at cycle 1 with m_err=1 and m_rdata=0xDEAD_BEEF. With the macro: err_cause=2, err_cnt=1.
- Read 0x2000_0000 (unmapped) -> m_ready at cycle 1, m_err=1, m_rdata=0xDEAD_BEEF, s_req=0.
- Read 0x1000_1004 with timer slave never acking -> s_req=4'b1000 for 16 cycles, then m_ready with m_err=1. In a separate run, ack on cycle 16 -> m_err=0.
- rst_n=0 in the 2nd WAIT cycle of a UART (0x1000_0000) read -> s_req=0 and m_ready=0 next cycle. A new request after reset completes normally.
